// File: rtl/previn_sched.sv
// previn_sched: frame-level sequencer for the PREVIN serial generator.
// Holds one 8-bit code per channel in a staging bank, snapshots it into a
// shadow bank on frame accept, then walks the enabled channels in ascending
// order: SCAN -> LOAD -> TRIG -> SHIFT (SHIFT_CYC cycles) per channel, then DONE.
// Optional build macro: PREVIN_SKIP_ZERO_EN -- when defined, SCAN treats a
// channel whose shadow code is 8'h00 as disabled.
module previn_sched #(
  parameter int unsigned NCH       = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned SHIFT_CYC = 9
) (
  input  logic           fdata_G,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [7:0]     cfg_data,
  input  logic [NCH-1:0] ch_en,
  input  logic           frame_start,
  input  logic           abort,
  output logic [7:0]     previn_code,
  output logic           previn_trig,
  output logic [AW-1:0]  ch_sel,
  output logic           busy,
  output logic           frame_done,
  output logic           seq_err
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_LOAD  = 3'd2,
    S_TRIG  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_stage  [NCH];
  logic [7:0]       r_shadow [NCH];
  logic [NCH-1:0]   r_mask;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;

  logic [7:0]       r_code;
  logic             r_trig;
  logic [AW-1:0]    r_ch_sel;
  logic             r_busy;
  logic             r_done;
  logic             r_seq_err;

  logic             w_found;
  logic [AW-1:0]    w_idx;
  logic             w_accept;
  logic             w_load_sel;
  logic             w_ptr_adv;
  logic [PW-1:0]    w_ptr_inc;
  logic             w_cfg_hit;

  assign previn_code = r_code;
  assign previn_trig = r_trig;
  assign ch_sel      = r_ch_sel;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign seq_err     = r_seq_err;

  assign w_cfg_hit = cfg_we && ({1'b0, cfg_addr} < PW'(NCH));
  assign w_ptr_inc = PW'(r_ch_sel) + PW'(1);

  // Lowest enabled shadow channel at or above the scan pointer.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
`ifdef PREVIN_SKIP_ZERO_EN
      if (r_mask[i] && (PW'(i) >= r_ptr) && (r_shadow[i] != 8'h00)) begin
`else
      if (r_mask[i] && (PW'(i) >= r_ptr)) begin
`endif
        w_found = 1'b1;
        w_idx   = AW'(i);
      end
    end
  end

  // Next-state decode; abort overrides every non-idle transition.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_sel  = 1'b0;
    w_ptr_adv   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start && !abort) begin
          w_state_nxt = S_SCAN;
          w_accept    = 1'b1;
        end
      end
      S_SCAN: begin
        w_state_nxt = w_found ? S_LOAD : S_DONE;
        w_load_sel  = w_found && !abort;
      end
      S_LOAD:  w_state_nxt = S_TRIG;
      S_TRIG:  w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SCAN;
          w_ptr_adv   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge fdata_G) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge fdata_G) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_trig    <= 1'b0;
      r_done    <= 1'b0;
      r_seq_err <= 1'b0;
      r_code    <= '0;
      r_ch_sel  <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_trig <= (w_state_nxt == S_TRIG);
      r_done <= (w_state_nxt == S_DONE);
      if (frame_start && (r_state != S_IDLE)) begin
        r_seq_err <= 1'b1;
      end
      if (w_load_sel) begin
        r_ch_sel <= w_idx;
        r_code   <= r_shadow[w_idx];
      end
    end
  end

  // Staging bank (written in any state), shadow snapshot, pointer and shift counter.
  always_ff @(posedge fdata_G) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_stage[i]  <= '0;
        r_shadow[i] <= '0;
      end
      r_mask <= '0;
      r_ptr  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_cfg_hit) begin
        r_stage[cfg_addr] <= cfg_data;
      end
      if (w_accept) begin
        for (int i = 0; i < NCH; i++) begin
          r_shadow[i] <= r_stage[i];
        end
        r_mask <= ch_en;
        r_ptr  <= '0;
      end else if (w_ptr_adv) begin
        r_ptr <= (w_ptr_inc > PW'(NCH)) ? PW'(NCH) : w_ptr_inc;
      end
      if (r_state == S_TRIG) begin
        r_cnt <= CW'(SHIFT_CYC - 1);
      end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/previn_sched.md
Name: previn_sched

Overview:
- Frame-level sequencer for the PREVIN serial generator.
- Holds one 8-bit PREVIN code per channel, written by the PC configuration path.
- On each frame start it walks the enabled channels in ascending order. For each channel it drives the channel select and the code, issues a one-cycle trigger, and waits a fixed shift window so the generator can finish shifting out before the next channel.

Parameters:
- NCH, 8, number of channels (2..16).
- AW, 3, channel address width; must satisfy 2^AW >= NCH.
- SHIFT_CYC, 9, cycles reserved per channel for serial shift-out (1..255).

Ports:
- fdata_G  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_we  input  1  staging-bank write strobe.
- cfg_addr  input  AW  staging-bank channel address.
- cfg_data  input  8  PREVIN code to write.
- ch_en  input  NCH  per-channel enable mask; latched at frame accept.
- frame_start  input  1  single-cycle request to run one frame.
- abort  input  1  terminate current frame.
- previn_code  output  8  code for the current channel (registered).
- previn_trig  output  1  one-cycle load pulse to the generator (registered).
- ch_sel  output  AW  current channel index (registered).
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse when a frame completes normally.
- seq_err  output  1  sticky flag: frame_start received while busy.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - All outputs 0.
  - Staging bank, shadow bank, shadow enable mask and scan pointer all cleared to 0.
- Staging bank:
  - cfg_we=1 writes cfg_data to entry cfg_addr in any state.
  - Writes with cfg_addr >= NCH are ignored.
- Frame accept (IDLE, frame_start=1, abort=0):
  - Copy staging bank to shadow bank and ch_en to the shadow mask.
  - Pointer <= 0; next state SCAN.
  - A write in the same cycle updates staging only; the shadow gets the pre-write value.
- SCAN (1 cycle):
  - Find the lowest enabled shadow channel with index >= pointer.
  - Found: next state LOAD, ch_sel <= index, previn_code <= shadow[index].
  - None: next state DONE.
- LOAD (1 cycle): outputs held stable; next state TRIG.
- TRIG (1 cycle): previn_trig=1; shift counter <= SHIFT_CYC-1; next state SHIFT.
- SHIFT:
  - Lasts SHIFT_CYC cycles; counter decrements to 0.
  - At 0: pointer <= ch_sel+1 (saturates at NCH); next state SCAN.
- DONE (1 cycle): frame_done=1; next state IDLE.
- Timing (frame_start sampled in cycle 0):
  - SCAN in cycle 1, LOAD in cycle 2, first previn_trig in cycle 3.
  - Each enabled channel costs 3+SHIFT_CYC cycles.
  - With k enabled channels, frame_done falls in cycle k*(3+SHIFT_CYC)+2.
- Output hold: previn_code and ch_sel keep their value until the next LOAD update or reset. They are not cleared in IDLE.
- frame_start while busy: ignored; seq_err <= 1, cleared only by reset.
- abort:
  - In any non-IDLE state, next state IDLE.
  - No frame_done is issued and no further trigger follows.
  - A trigger already asserted in the abort cycle completes.
  - In IDLE, abort together with frame_start means the frame is not accepted.
- Empty shadow mask: frame runs SCAN -> DONE with frame_done in cycle 2 and no trigger.
- Exactly one previn_trig per enabled channel per frame, in ascending index order.

Optional Feature:
- Macro: PREVIN_SKIP_ZERO_EN.
- Defined: SCAN treats a channel whose shadow code is 8'h00 as disabled. No trigger is issued for it and it takes no cycles.
- Undefined: zero codes are sequenced like any other code.

Test Plan:
- Reset, then staging ch0=8'hA5, ch2=8'h3C, ch_en=8'b0000_0101, frame_start in cycle 0 (SHIFT_CYC=9) -> previn_trig in cycles 3 and 15, with (ch_sel,previn_code)=(0,A5) and (2,3C); frame_done in cycle 26; busy high cycles 1..26.
- ch_en=8'h00, frame_start -> no trigger; frame_done in cycle 2; previn_code unchanged.
- Accepted frame with cfg_we to ch0=8'h11 in the same cycle (old value A5) -> this frame sends A5; next frame sends 11.
- frame_start in cycle 5 of a running frame -> seq_err=1 and stays 1; the frame finishes unchanged. Only reset clears seq_err.
- abort in cycle 8 with ch_en=8'hFF -> IDLE in cycle 9; busy=0; no frame_done; exactly one trigger total (cycle 3).
- PREVIN_SKIP_ZERO_EN defined, codes ch0=00, ch1=7F, ch_en=8'h03 -> single trigger in cycle 3 with ch_sel=1; frame_done in cycle 14. Macro undefined -> triggers in cycles 3 and 15; frame_done in cycle 26.
